// File: rtl/regfile_mp.sv
// regfile_mp: multi-port register file with scoreboard and post-reset scrub.
//
// After reset the file walks every register from index 1 upward and zeroes it,
// one per cycle; only then does it raise ready and accept writes, scoreboard
// updates and reads. Register 0 is hardwired to read as zero.
//
// Ports:
//   clk, rst            clock (rising edge), asynchronous active-low reset
//   ready               high once the scrub has finished
//   we0/waddr0/wdata0   write port 0
//   we1/waddr1/wdata1   write port 1, wins over port 0 on the same address
//   re, raddr           per-read-port enable and packed addresses
//   rdata, rbusy        packed read data (with write bypass) and busy flags
//   sb_set, sb_addr     mark a register busy for an issuing producer
module regfile_mp #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned NUM_RD = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  output logic                       ready,
  input  logic                       we0,
  input  logic [ADDR_W-1:0]          waddr0,
  input  logic [DATA_W-1:0]          wdata0,
  input  logic                       we1,
  input  logic [ADDR_W-1:0]          waddr1,
  input  logic [DATA_W-1:0]          wdata1,
  input  logic [NUM_RD-1:0]          re,
  input  logic [NUM_RD*ADDR_W-1:0]   raddr,
  output logic [NUM_RD*DATA_W-1:0]   rdata,
  output logic [NUM_RD-1:0]          rbusy,
  input  logic                       sb_set,
  input  logic [ADDR_W-1:0]          sb_addr
);

  localparam int unsigned NumRegs = 2 ** ADDR_W;

  typedef enum logic {StScrub, StRun} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   scrub_cnt_q, scrub_cnt_d;
  logic [NumRegs-1:0]  busy_q, busy_d;
  logic [DATA_W-1:0]   regs_q [NumRegs];

  assign ready = (state_q == StRun);

  always_comb begin
    state_d     = state_q;
    scrub_cnt_d = scrub_cnt_q;
    unique case (state_q)
      StScrub: begin
        scrub_cnt_d = scrub_cnt_q + 1'b1;
        if (scrub_cnt_q == {ADDR_W{1'b1}}) state_d = StRun;
      end
      StRun: ;
      default: state_d = StScrub;
    endcase
  end

  // Clears first, then the set, so a new producer claiming the register being
  // written back keeps it busy.
  always_comb begin
    busy_d = busy_q;
    if (state_q == StRun) begin
      if (we0) busy_d[waddr0] = 1'b0;
      if (we1) busy_d[waddr1] = 1'b0;
      if (sb_set && (sb_addr != '0)) busy_d[sb_addr] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StScrub;
      scrub_cnt_q <= ADDR_W'(1);
      busy_q      <= '0;
    end else begin
      state_q     <= state_d;
      scrub_cnt_q <= scrub_cnt_d;
      busy_q      <= busy_d;
    end
  end

  // Storage is not reset; the scrub is what zeroes it. Port 1 is written
  // last so it takes the slot on an address collision.
  always_ff @(posedge clk) begin
    if (state_q == StScrub) begin
      regs_q[scrub_cnt_q] <= '0;
    end else begin
      if (we0 && (waddr0 != '0)) regs_q[waddr0] <= wdata0;
      if (we1 && (waddr1 != '0)) regs_q[waddr1] <= wdata1;
    end
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    logic              hit0, hit1;
    logic [DATA_W-1:0] rd;

    assign ra   = raddr[k*ADDR_W +: ADDR_W];
    assign hit0 = we0 && (waddr0 == ra);
    assign hit1 = we1 && (waddr1 == ra);

    always_comb begin
      rd = '0;
      if (ready && re[k] && (ra != '0)) begin
        if (hit1)      rd = wdata1;
        else if (hit0) rd = wdata0;
        else           rd = regs_q[ra];
      end
    end

    assign rdata[k*DATA_W +: DATA_W] = rd;
    // A same-cycle write supplies the value through the bypass, so not busy.
    assign rbusy[k] = ready & re[k] & busy_q[ra] & ~hit0 & ~hit1;
  end

endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: randomized check of regfile_mp against a behavioural model,
// plus directed scenarios with hand-computed expectations.
module tb_regfile_mp;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 2;
  localparam int NREG = 32;

  logic            clk = 1'b0;
  logic            rst;
  logic            ready;
  logic            we0, we1, sb_set;
  logic [AW-1:0]   waddr0, waddr1, sb_addr;
  logic [DW-1:0]   wdata0, wdata1;
  logic [NR-1:0]   re;
  logic [NR*AW-1:0] raddr;
  logic [NR*DW-1:0] rdata;
  logic [NR-1:0]   rbusy;

  int n_cmp = 0;
  int n_bad = 0;

  regfile_mp #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR)) dut (
    .clk(clk), .rst(rst), .ready(ready),
    .we0(we0), .waddr0(waddr0), .wdata0(wdata0),
    .we1(we1), .waddr1(waddr1), .wdata1(wdata1),
    .re(re), .raddr(raddr), .rdata(rdata), .rbusy(rbusy),
    .sb_set(sb_set), .sb_addr(sb_addr)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  logic [DW-1:0] m_regs [NREG];
  bit            m_busy [NREG];
  int            m_scrub_left = 31;  // registers still to be zeroed

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_scrub_left = NREG - 1;
      for (int i = 0; i < NREG; i++) m_busy[i] = 0;
    end else if (m_scrub_left > 0) begin
      m_regs[NREG - m_scrub_left] = '0;
      m_scrub_left--;
    end else begin
      if (we0 && waddr0 != 0) m_regs[waddr0] = wdata0;
      if (we1 && waddr1 != 0) m_regs[waddr1] = wdata1;
      if (we0) m_busy[waddr0] = 0;
      if (we1) m_busy[waddr1] = 0;
      if (sb_set && sb_addr != 0) m_busy[sb_addr] = 1;
    end
  end

  function automatic logic m_ready();
    return rst === 1'b1 && m_scrub_left == 0;
  endfunction

  function automatic logic [AW-1:0] ra_of(int k);
    return raddr[k*AW +: AW];
  endfunction

  function automatic logic [DW-1:0] exp_rdata(int k);
    logic [AW-1:0] a;
    a = ra_of(k);
    if (!m_ready() || !re[k] || a == 0) return '0;
    if (we1 && waddr1 == a) return wdata1;
    if (we0 && waddr0 == a) return wdata0;
    return m_regs[a];
  endfunction

  function automatic logic exp_rbusy(int k);
    logic [AW-1:0] a;
    a = ra_of(k);
    if (!m_ready() || !re[k]) return 1'b0;
    if ((we1 && waddr1 == a) || (we0 && waddr0 == a)) return 1'b0;
    return m_busy[a];
  endfunction

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%h required 0x%h at %0t", name, act, exp, $time);
    end
  endtask

  // Every-cycle compare, sampled on the falling edge.
  bit cmp_en = 0;
  always @(negedge clk) begin
    if (cmp_en) begin
      check("ready", {31'b0, ready}, {31'b0, m_ready()});
      for (int k = 0; k < NR; k++) begin
        check($sformatf("rdata[%0d]", k), rdata[k*DW +: DW], exp_rdata(k));
        check($sformatf("rbusy[%0d]", k), {31'b0, rbusy[k]}, {31'b0, exp_rbusy(k)});
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic idle();
    we0 = 0; we1 = 0; sb_set = 0; re = '0;
    waddr0 = '0; waddr1 = '0; sb_addr = '0; wdata0 = '0; wdata1 = '0; raddr = '0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rd0(input logic [AW-1:0] a);
    re = 2'b01; raddr[AW-1:0] = a;
    #1;
  endtask

  // Counts cycles from here until ready goes high, bounded.
  task automatic wait_ready(output int n);
    n = 0;
    while (ready !== 1'b1 && n < 200) begin
      step();
      n++;
    end
  endtask

  int n;

  initial begin
    idle();
    rst = 1'b0;
    repeat (3) step();
    cmp_en = 1;
    check("reset ready", {31'b0, ready}, 32'd0);
    check("reset rbusy", {30'b0, rbusy}, 32'd0);
    re = 2'b11; raddr = {5'd3, 5'd7}; #1;
    check("reset rdata", rdata[31:0] | rdata[63:32], 32'd0);
    idle();

    // 1: scrub timing and zeroed contents.
    rst = 1'b1;
    wait_ready(n);
    check("scrub cycles", n, 32'd31);
    for (int a = 0; a < NREG; a += 2) begin
      re = 2'b11; raddr = {5'(a + 1), 5'(a)}; #1;
      check("scrub zero p0", rdata[31:0], 32'd0);
      check("scrub zero p1", rdata[63:32], 32'd0);
    end
    idle();

    // 2: basic write/read and register 0.
    we0 = 1; waddr0 = 5; wdata0 = 32'hDEADBEEF;
    step(); idle();
    rd0(5);
    check("basic read", rdata[31:0], 32'hDEADBEEF);
    idle();
    we0 = 1; waddr0 = 0; wdata0 = 32'h1234;
    step(); idle();
    rd0(0);
    check("reg0 read", rdata[31:0], 32'd0);
    idle();

    // 3: dual write collision.
    we0 = 1; waddr0 = 7; wdata0 = 32'h11;
    we1 = 1; waddr1 = 7; wdata1 = 32'h22;
    rd0(7);
    check("collision bypass", rdata[31:0], 32'h22);
    step(); idle();
    rd0(7);
    check("collision stored", rdata[31:0], 32'h22);
    idle();

    // 4: per-port bypass.
    re = 2'b11; raddr = {5'd4, 5'd3};
    we0 = 1; waddr0 = 3; wdata0 = 32'hAA;
    we1 = 1; waddr1 = 4; wdata1 = 32'hBB;
    #1;
    check("bypass p0", rdata[31:0], 32'hAA);
    check("bypass p1", rdata[63:32], 32'hBB);
    step(); idle();

    // 5: scoreboard set / set-beats-clear / clear.
    sb_set = 1; sb_addr = 9;
    step(); idle();
    rd0(9);
    check("sb set", {31'b0, rbusy[0]}, 32'd1);
    we0 = 1; waddr0 = 9; wdata0 = 32'h55; sb_set = 1; sb_addr = 9;
    step(); idle();
    rd0(9);
    check("sb set wins", {31'b0, rbusy[0]}, 32'd1);
    check("reg9 value", rdata[31:0], 32'h55);
    idle();
    we1 = 1; waddr1 = 9; wdata1 = 32'h55;
    step(); idle();
    rd0(9);
    check("sb cleared", {31'b0, rbusy[0]}, 32'd0);
    idle();

    // 6: reset mid-RUN with busy[9]=1, reg 9 = 0x55.
    sb_set = 1; sb_addr = 9;
    step(); idle();
    rd0(9);
    check("pre-reset busy", {31'b0, rbusy[0]}, 32'd1);
    rst = 1'b0; #1;
    check("async ready low", {31'b0, ready}, 32'd0);
    check("async rbusy low", {31'b0, rbusy[0]}, 32'd0);
    step();
    rst = 1'b1;
    wait_ready(n);
    check("rescrub cycles", n, 32'd31);
    rd0(9);
    check("reg9 scrubbed", rdata[31:0], 32'd0);
    check("busy9 cleared", {31'b0, rbusy[0]}, 32'd0);
    idle();

    // Randomized traffic with occasional resets.
    for (int c = 0; c < 3000; c++) begin
      we0 = 1'($urandom); waddr0 = 5'($urandom); wdata0 = $urandom;
      we1 = 1'($urandom); waddr1 = 5'($urandom); wdata1 = $urandom;
      sb_set = 1'($urandom); sb_addr = 5'($urandom);
      re = 2'($urandom); raddr = 10'($urandom);
      // Bias reads toward write addresses to exercise the bypass.
      if ($urandom_range(3) == 0) raddr[AW-1:0] = waddr1;
      if ($urandom_range(3) == 0) raddr[2*AW-1:AW] = waddr0;
      if ($urandom_range(399) == 0) rst = 1'b0;
      else rst = 1'b1;
      step();
    end
    rst = 1'b1;
    idle();
    repeat (2) step();

    cmp_en = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
